// File: rtl/anneal_pkg.sv
// Shared constants, FSM state type and lane-extract helper for the coefficient RAM scheduler.
package anneal_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 6;
  localparam int LANES      = 8;
  localparam int LANE_CNT_W = $clog2(LANES);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] lane_extract(
    input logic [DATA_WIDTH*LANES-1:0] word,
    input int unsigned                 idx
  );
    return word[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/anneal_lane_unpack.sv
// Parallel-load holding register for one host word; presents the short selected by sel.
// Loads in the handshake cycle, so lane 0 is available on the first WRITE cycle.
module anneal_lane_unpack
  import anneal_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [DATA_WIDTH*LANES-1:0] word,
  input  logic [LANE_CNT_W-1:0]       sel,
  output logic [DATA_WIDTH-1:0]       lane
);

  logic [DATA_WIDTH-1:0] regs [LANES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) regs[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < LANES; i++) regs[i] <= lane_extract(word, i);
    end
  end

  assign lane = regs[sel];

endmodule

// File: rtl/anneal_ram_sched.sv
// Round-robin owner of the coefficient RAM port: host bursts of LANES shorts vs single DSP reads.
// Host burst occupies LANES cycles after the handshake; DSP read data follows its grant by one cycle.
module anneal_ram_sched #(
  parameter int DATA_WIDTH = anneal_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = anneal_pkg::ADDR_WIDTH,
  parameter int LANES      = anneal_pkg::LANES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        h_valid,
  output logic                        h_ready,
  input  logic [ADDR_WIDTH-1:0]       h_addr,
  input  logic [DATA_WIDTH*LANES-1:0] h_data,
  output logic                        h_done,
  input  logic                        d_req,
  input  logic [ADDR_WIDTH-1:0]       d_addr,
  output logic                        d_gnt,
  output logic                        d_rvalid,
  output logic [DATA_WIDTH-1:0]       d_rdata,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_data,
  output logic                        ram_we,
  input  logic [DATA_WIDTH-1:0]       ram_q,
  output logic                        busy
);

  import anneal_pkg::*;

  state_t                  state;
  logic [LANE_CNT_W-1:0]   lane_cnt;
  logic                    last_host;
  logic [ADDR_WIDTH-1:0]   base;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic [DATA_WIDTH-1:0]   lane_q;
  logic                    idle;
  logic                    host_win;
  logic                    dsp_win;
  logic                    h_fire;

  assign idle     = (state == IDLE);
  assign host_win = h_valid & (~d_req | ~last_host);
  assign dsp_win  = d_req & ~host_win;
  assign h_ready  = idle & host_win;
  assign d_gnt    = idle & dsp_win;
  assign h_fire   = h_valid & h_ready;
  assign busy     = (state == WRITE);

  anneal_lane_unpack u_unpack (
    .clk   (clk),
    .reset (reset),
    .load  (h_fire),
    .word  (h_data),
    .sel   (lane_cnt),
    .lane  (lane_q)
  );

  // Read address goes straight to the RAM in the grant cycle; its own address register gives the 1-cycle latency.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_hold;
    ram_data = '0;
    if (state == WRITE) begin
      ram_we   = 1'b1;
      ram_addr = base + ADDR_WIDTH'(lane_cnt);
      ram_data = lane_q;
    end else if (d_gnt) begin
      ram_addr = d_addr;
    end
  end

  assign d_rdata = d_rvalid ? ram_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      last_host <= 1'b0;
      base      <= '0;
      addr_hold <= '0;
      h_done    <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      h_done    <= 1'b0;
      d_rvalid  <= d_gnt;
      addr_hold <= ram_addr;
      case (state)
        IDLE: begin
          if (h_fire) begin
            base      <= h_addr;
            last_host <= 1'b1;
            lane_cnt  <= '0;
            state     <= WRITE;
          end else if (d_gnt) begin
            last_host <= 1'b0;
          end
        end
        WRITE: begin
          if (lane_cnt == LANE_CNT_W'(LANES - 1)) begin
            lane_cnt <= '0;
            h_done   <= 1'b1;
            state    <= IDLE;
          end else begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anneal_ram_sched.sv
// Scoreboard bench for anneal_ram_sched with a behavioural single-port RAM (registered read address).
module tb_anneal_ram_sched;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NL = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            h_valid = 1'b0;
  logic            h_ready;
  logic [AW-1:0]   h_addr = '0;
  logic [DW*NL-1:0] h_data = '0;
  logic            h_done;
  logic            d_req = 1'b0;
  logic [AW-1:0]   d_addr = '0;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic            ram_we;
  logic [DW-1:0]   ram_q;
  logic            busy;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int   dq[$];
  int   ev[$];

  logic [DW-1:0] mem   [64];
  logic [DW-1:0] model [64];
  logic [AW-1:0] addr_reg = '0;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  anneal_ram_sched dut (
    .clk      (clk),
    .reset    (reset),
    .h_valid  (h_valid),
    .h_ready  (h_ready),
    .h_addr   (h_addr),
    .h_data   (h_data),
    .h_done   (h_done),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .ram_q    (ram_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    addr_reg <= ram_addr;
  end
  assign ram_q = mem[addr_reg];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor pops and compares; handshakes push future expectations (always for later cycles).
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (ram_we) begin
        if (wq.size() == 0) chk("wr_unexpected", 32'(ram_we), 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          chk("wr_addr", 32'(ram_addr), 32'(e.addr));
          chk("wr_data", 32'(ram_data), 32'(e.data));
          model[e.addr] = e.data;
        end
      end
      if (h_done) begin
        if (dq.size() == 0) chk("done_unexpected", 32'(h_done), 32'd0);
        else chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
      end
      if (d_rvalid) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 32'(d_rvalid), 32'd0);
        else begin
          e = rq.pop_front();
          chk("rd_cycle", 32'(cyc), 32'(e.cyc));
          chk("rd_data", 32'(d_rdata), 32'(e.data));
        end
      end
      if (h_valid && h_ready) begin
        for (int i = 0; i < NL; i++)
          wq.push_back('{cyc + 1 + i, h_addr + AW'(i), h_data[DW*i +: DW]});
        dq.push_back(cyc + NL + 1);
        ev.push_back(1);
      end
      if (d_req && d_gnt) begin
        rq.push_back('{cyc + 1, d_addr, model[d_addr]});
        ev.push_back(2);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*NL-1:0] mk(input logic [DW-1:0] first);
    logic [DW*NL-1:0] w;
    for (int i = 0; i < NL; i++) w[DW*i +: DW] = first + DW'(i);
    return w;
  endfunction

  task automatic host_send(input logic [AW-1:0] a, input logic [DW*NL-1:0] w);
    logic hit;
    hit = 1'b0;
    h_valid = 1'b1; h_addr = a; h_data = w;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      hit = h_ready;
      step(1);
    end
    h_valid = 1'b0;
    chk("host_handshake", 32'(hit), 32'd1);
  endtask

  task automatic dsp_read(input logic [AW-1:0] a);
    logic hit;
    hit = 1'b0;
    d_req = 1'b1; d_addr = a;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      hit = d_gnt;
      step(1);
    end
    d_req = 1'b0;
    chk("dsp_grant", 32'(hit), 32'd1);
    step(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]   = 16'hA000 + DW'(i);
      model[i] = 16'hA000 + DW'(i);
    end

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_h_done", 32'(h_done), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);

    // Single burst to 8..15, then read back
    host_send(6'd8, mk(16'h0001));
    step(10);
    chk("burst_ram8", 32'(mem[8]), 32'h0001);
    chk("burst_ram15", 32'(mem[15]), 32'h0008);
    for (int a = 8; a < 16; a++) dsp_read(AW'(a));

    // Wrap-around burst at 62
    host_send(6'd62, mk(16'h0201));
    step(10);
    chk("wrap_ram0", 32'(mem[0]), 32'h0203);
    chk("wrap_ram63", 32'(mem[63]), 32'h0202);
    chk("wrap_ram6", 32'(mem[6]), 32'hA006);
    dsp_read(6'd0);
    dsp_read(6'd63);

    // Contention right after reset: host first, DSP granted in the h_done cycle
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    h_valid = 1'b1; h_addr = 6'd32; h_data = mk(16'h0301);
    d_req = 1'b1; d_addr = 6'd32;
    @(negedge clk);
    chk("cont_h_ready", 32'(h_ready), 32'd1);
    chk("cont_gnt_low", 32'(d_gnt), 32'd0);
    step(1);
    h_valid = 1'b0;
    for (int k = 1; k < 9; k++) begin
      @(negedge clk);
      chk("cont_gnt_low", 32'(d_gnt), 32'd0);
      step(1);
    end
    @(negedge clk);
    chk("cont_gnt", 32'(d_gnt), 32'd1);
    chk("cont_done", 32'(h_done), 32'd1);
    step(1);
    d_req = 1'b0;
    step(3);

    // Round robin with both requesters held
    ev.delete();
    h_valid = 1'b1; h_addr = 6'd40; h_data = mk(16'h0401);
    d_req = 1'b1; d_addr = 6'd40;
    for (int k = 0; k < 80 && ev.size() < 4; k++) step(1);
    h_valid = 1'b0;
    d_req = 1'b0;
    chk("rr_events", 32'(ev.size()), 32'd4);
    for (int i = 0; i < ev.size() && i < 4; i++)
      chk("rr_order", 32'(ev[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    step(12);

    // Back-to-back reads of 0,1,2
    d_req = 1'b1; d_addr = 6'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_gnt", 32'(d_gnt), 32'd1);
      step(1);
      d_addr = AW'(k + 1);
    end
    d_req = 1'b0;
    @(negedge clk);
    chk("b2b_gnt_off", 32'(d_gnt), 32'd0);
    step(3);

    // Reset at lane 3 of a burst to 16
    begin
      logic hit;
      hit = 1'b0;
      h_valid = 1'b1; h_addr = 6'd16; h_data = mk(16'h1601);
      for (int k = 0; k < 40 && !hit; k++) begin
        @(negedge clk);
        hit = h_ready;
        step(1);
      end
      h_valid = 1'b0;
      chk("abort_handshake", 32'(hit), 32'd1);
    end
    step(3);
    chk("abort_lane3_addr", 32'(ram_addr), 32'd19);
    reset = 1'b1;
    wq.delete();
    dq.delete();
    @(negedge clk);
    chk("abort_we", 32'(ram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    h_valid = 1'b1; h_addr = 6'd48; h_data = mk(16'h3001);
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_h_ready", 32'(h_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    step(1);
    h_valid = 1'b0;
    step(12);
    chk("abort_ram18", 32'(mem[18]), 32'h1603);
    chk("abort_ram19", 32'(mem[19]), 32'hA013);
    for (int a = 16; a < 20; a++) dsp_read(AW'(a));
    dsp_read(6'd48);
    step(4);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
